// File: rtl/uart_pkg.sv
// Shared UART frame definitions.
// Used by both the transmit and receive paths so the frame format matches.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered storage and a level counter.
// Full/empty come from the level, so pointers simply wrap.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [LW-1:0]    lvl_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (lvl_q == LW'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame serialiser, LSB first.
// io_txd is registered from the current state, so the line lags the FSM by one clock.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_tx_valid,
  output logic                        io_tx_ready,
  input  logic [DATA_BITS-1:0]        io_tx_payload,
  output logic                        io_txd,
  output logic                        io_busy,
  output logic [$clog2(FIFO_DEPTH):0] io_fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PARITY_NONE);
  localparam bit PAR_INIT = (PARITY == PARITY_ODD);

  tx_state_t            state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 txd_q;

  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 baud_end;
  logic                 stop_end;
  logic                 pop;

  assign baud_end = (cnt_q == CNT_LAST);
  assign stop_end = (state_q == TX_STOP) & baud_end & (bit_q == STOP_LAST);
  assign pop      = ~empty & ((state_q == TX_IDLE) | stop_end);

  assign io_tx_ready = ~full;
  assign io_txd      = txd_q;
  assign io_busy     = (state_q != TX_IDLE) | ~empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (io_tx_valid),
    .din_i   (io_tx_payload),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (io_fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      if (state_q != TX_IDLE)
        cnt_q <= baud_end ? '0 : cnt_q + CW'(1);
      unique case (state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            par_q   <= PAR_INIT;
            cnt_q   <= '0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          txd_q <= 1'b0;
          if (baud_end) begin
            bit_q   <= '0;
            state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          txd_q <= shift_q[0];
          if (baud_end) begin
            par_q   <= par_q ^ shift_q[0];
            shift_q <= shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= HAS_PAR ? TX_PARITY : TX_STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        TX_PARITY: begin
          txd_q <= par_q;
          if (baud_end) begin
            bit_q   <= '0;
            state_q <= TX_STOP;
          end
        end
        TX_STOP: begin
          txd_q <= 1'b1;
          if (baud_end) begin
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              // chain straight into the next start bit when data is waiting
              if (pop) begin
                shift_q <= head;
                par_q   <= PAR_INIT;
                state_q <= TX_START;
              end else begin
                state_q <= TX_IDLE;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three parameterisations, one mid-bit line monitor.
// DUT0 is 8N1, DUT1 even parity with 2 stop bits, DUT2 odd parity with 1 stop bit.
module tb_uart_tx_buffered;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] txd;
  logic [2:0] bsy;
  logic [7:0] pl  [3];
  logic [2:0] lvl [3];

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         bcnt [3] = '{0, 0, 0};
  logic [7:0] sbq[$];
  int         starts[$];
  bit         sb_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (bsy[k]) bcnt[k] <= bcnt[k] + 1;
  end

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .reset(rst),
    .io_tx_valid(vld[0]), .io_tx_ready(rdy[0]),
    .io_tx_payload(pl[0]), .io_txd(txd[0]),
    .io_busy(bsy[0]), .io_fifo_level(lvl[0])
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .reset(rst),
    .io_tx_valid(vld[1]), .io_tx_ready(rdy[1]),
    .io_tx_payload(pl[1]), .io_txd(txd[1]),
    .io_busy(bsy[1]), .io_fifo_level(lvl[1])
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u2 (
    .clk(clk), .reset(rst),
    .io_tx_valid(vld[2]), .io_tx_ready(rdy[2]),
    .io_tx_payload(pl[2]), .io_txd(txd[2]),
    .io_busy(bsy[2]), .io_fifo_level(lvl[2])
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    vld[k] = 1'b1;
    pl[k]  = d;
    while (!rdy[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("send_timeout", n, 0);
      vld[k] = 1'b0;
      return;
    end
    @(posedge clk);
    if (sb_en) sbq.push_back(d);
    #1 vld[k] = 1'b0;
  endtask

  task automatic rx_frame(input int k, input int par, input int nst,
                          output logic [7:0] d, output logic pb,
                          output int t0);
    int n = 0;
    d  = '0;
    pb = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (txd[k] !== 1'b0 && n < 3000);
    if (n >= 3000) chk("rx_timeout", n, 0);
    t0 = cyc;
    @(negedge clk);
    chk("start_bit", txd[k], 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      d[i] = txd[k];
    end
    if (par != 0) begin
      repeat (CPB) @(negedge clk);
      pb = txd[k];
    end
    for (int s = 0; s < nst; s++) begin
      repeat (CPB) @(negedge clk);
      chk("stop_bit", txd[k], 1);
    end
  endtask

  task automatic mon(input int nfr);
    logic [7:0] d;
    logic       pb;
    int         t;
    for (int i = 0; i < nfr; i++) begin
      rx_frame(0, 0, 1, d, pb, t);
      starts.push_back(t);
      if (sbq.size() == 0) chk("sb_underflow", d, -1);
      else chk("data", d, sbq.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] d;
    logic       pb;
    int         t;
    int         b0;
    int         lows;

    rst = 1'b1;
    vld = '0;
    for (int k = 0; k < 3; k++) pl[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd[0], 1);
    chk("rst_ready", rdy[0], 1);
    chk("rst_busy", bsy[0], 0);
    chk("rst_level", lvl[0], 0);
    chk("rst_txd1", txd[1], 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single 0x55 frame, latency and exact length
    b0 = bcnt[0];
    vld[0] = 1'b1;
    pl[0]  = 8'h55;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    chk("t1_lvl_n", lvl[0], 1);
    chk("t1_txd_n", txd[0], 1);
    @(negedge clk);
    chk("t1_lvl_n1", lvl[0], 0);
    chk("t1_busy_n1", bsy[0], 1);
    chk("t1_txd_n1", txd[0], 1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      repeat ((i == 0) ? 2 : CPB) @(negedge clk);
      chk("t1_bit", txd[0], fr[i]);
    end
    @(negedge clk);
    chk("t1_busy_end", bsy[0], 1);
    @(negedge clk);
    chk("t1_busy_off", bsy[0], 0);
    chk("t1_txd_idle", txd[0], 1);
    repeat (2) @(negedge clk);
    chk("t1_len", bcnt[0] - b0, 41);

    // 2: back-to-back bytes, fill to full, contiguous frames
    sb_en = 1'b1;
    starts.delete();
    fork
      begin
        send(0, 8'hA5);
        send(0, 8'h3C);
        send(0, 8'hFF);
        send(0, 8'h00);
        send(0, 8'h5A);
        @(negedge clk);
        chk("t2_full_lvl", lvl[0], 4);
        chk("t2_full_rdy", rdy[0], 0);
      end
      mon(5);
    join
    for (int i = 1; i < 5; i++)
      chk("t2_gap", starts[i] - starts[i-1], 40);

    // 3: parity and stop-bit variants
    sb_en = 1'b0;
    b0 = bcnt[1];
    fork
      send(1, 8'h07);
      rx_frame(1, 1, 2, d, pb, t);
    join
    chk("t3_even_data", d, 8'h07);
    chk("t3_even_par", pb, 1);
    repeat (6) @(negedge clk);
    chk("t3_even_len", bcnt[1] - b0, 49);
    b0 = bcnt[2];
    fork
      send(2, 8'h07);
      rx_frame(2, 2, 1, d, pb, t);
    join
    chk("t3_odd_data", d, 8'h07);
    chk("t3_odd_par", pb, 0);
    repeat (6) @(negedge clk);
    chk("t3_odd_len", bcnt[2] - b0, 45);

    // 4: reset during data bit 3, queued byte must be flushed
    send(0, 8'h0F);
    send(0, 8'h33);
    repeat (19) @(negedge clk);
    chk("t4_bit3", txd[0], 1);
    chk("t4_lvl_pre", lvl[0], 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_txd", txd[0], 1);
    chk("t4_rst_lvl", lvl[0], 0);
    chk("t4_rst_rdy", rdy[0], 1);
    chk("t4_rst_busy", bsy[0], 0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
    end
    chk("t4_quiet", lows, 0);
    sb_en = 1'b1;
    sbq.delete();
    fork
      send(0, 8'h81);
      mon(1);
    join

    // 5: 256 incrementing bytes through the full FIFO
    starts.delete();
    fork
      for (int i = 0; i < 256; i++) send(0, 8'(i));
      mon(256);
    join
    chk("t5_sb_left", sbq.size(), 0);
    repeat (4) @(negedge clk);
    chk("t5_busy_off", bsy[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
